dual_reservation_station: RTL and testbench
===========================================

Name: dual_reservation_station

Overview:
- Two-entry reservation station between decode/rename and one execution unit of the OOO core.
- Decode writes an instruction with two operands; each operand is either a value or a pending ROB tag.
- Entries capture pending operands from the result broadcast bus.
- The lowest-index entry whose operands are both ready is presented for issue and freed when issue is not stalled.

Parameters:
- ROBsize, 32, number of ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), ROB tag width.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- decodeROBTag1_i  in  ROBsizeLog  ROB tag for operand 1.
- decodeROBTag2_i  in  ROBsizeLog  ROB tag for operand 2.
- decodeROBTag_i  in  ROBsizeLog  destination ROB tag.
- decodeWriteEn_i  in  1  decode requests an entry write.
- decodeROBval1_i  in  65  operand 1; bit 64 = ready, bits 63:0 = value.
- decodeROBval2_i  in  65  operand 2; same format.
- decodeCommands_i  in  10  opaque execution command.
- stall_o  out  1  both entries busy; decode must hold.
- issueROBTag_i  in  ROBsizeLog  broadcast result tag.
- issueROBval_i  in  65  broadcast result; bit 64 = valid, bits 63:0 = value.
- stall_i  in  1  downstream stall; blocks issue.
- reservationStationVal1_o  out  64  selected operand 1 value.
- reservationStationVal2_o  out  64  selected operand 2 value.
- reservationStationCommands_o  out  10  selected command.
- reservationStationTag_o  out  ROBsizeLog  selected destination tag.
- ready_o  out  1  some entry is ready to issue.

Behaviour:
- Entry state: busy, rdy1, rdy2, val1[63:0], val2[63:0], tag1, tag2, dest tag, cmd[9:0].
- Reset (async, reset_i=0): all fields cleared, so ready_o=0, stall_o=0 and all data outputs 0.
- Allocation:
  - Select the lowest-index non-busy entry (one-hot priority, bit 0 highest).
  - If decodeWriteEn_i=1, that entry loads all decode fields at the clock edge.
  - If both entries are busy, stall_o=1 and the write is dropped; decode holds and retries.
  - An entry that is busy in the current cycle is never reallocated in that cycle, even if it issues then.
- Operand capture at write:
  - rdyN/valN come from decodeROBvalN_i[64] and [63:0].
  - If the operand is not ready, issueROBval_i[64]=1 and issueROBTag_i==decodeROBTagN_i in the same cycle, the broadcast value is stored and rdyN=1.
- Wakeup:
  - Each cycle, every busy entry with rdyN=0, tagN==issueROBTag_i and issueROBval_i[64]=1 loads issueROBval_i[63:0] and sets rdyN.
  - Both operands may wake on the same broadcast.
  - Both entries may wake on the same broadcast.
  - A broadcast with bit 64=0 is ignored.
- Entry ready = busy & rdy1 & rdy2, registered state only (no same-cycle broadcast bypass).
- ready_o = OR of entry ready flags.
- Issue select:
  - One-hot priority over entry ready flags; entry 0 wins.
  - Output mux shows entry 1 fields only when entry 1 is selected, else entry 0 fields.
  - Entry 0 fields appear even when nothing is ready.
  - Outputs are combinational from registered state.
- Per-entry stall = ~selected | stall_i.
  - A selected ready entry with stall_i=0 clears busy at the clock edge (issued).
  - Other entries hold.
- Latency:
  - Write at edge N gives ready_o at N+1 when the operands were ready at write.
  - Wakeup at edge N gives ready_o in cycle N+1.
- Simultaneous write and issue in one cycle are independent (different entries).

Decomposition:
- Package: ROB-word typedef (65-bit, ready flag + 64-bit value), command width constant 10, operand value width constant 64.
- Sub-module reservation_station (one entry): write, wakeup, busy/ready, stall-gated release. Instantiated twice.
- Generic bsg_priority_encode_one_hot_out (width_p=2, lo_to_hi_p=1), used for both allocation and issue select.

Test Plan:
- Reset -> stall_o=0, ready_o=0, outputs 0.
- One write: val1=65'h1_0000_0000_0000_000a, val2=…000b, dest tag 3, cmd 10 -> next cycle ready_o=1, Val1=0xA, Val2=0xB, Tag=3, Cmd=10; entry freed the following edge.
- Five back-to-back ready writes (ROBsize=8): each issues one cycle after its write, in order; stall_o stays 0.
- Non-ready writes waiting on tags (1,2)/dest 3, (4,5)/dest 6, (7,8)/dest 9:
  - The third write sees stall_o=1 and is held.
  - Broadcasts tag1=0x..a0 and tag2=0x..b0 -> issue Val1=0xa0, Val2=0xb0, Tag=3.
  - Later tags 4/5 and 7/8 wake the remaining instructions in order.
- Both entries wait on tag 10 (dest 11); one broadcast tag 10, value 0xd -> both ready the same cycle; entry 0 issues first, entry 1 next cycle, both Val1=Val2=0xd.
- stall_i=1 with two ready writes -> stall_o=1, ready_o=1, nothing freed; stall_i=0 -> entry 0 then entry 1 issue on consecutive edges, then stall_o=0.

Source files
------------

// File: rtl/dual_reservation_station_pkg.sv
// Shared types and widths for the dual-entry reservation station.
package dual_reservation_station_pkg;

   localparam int unsigned VAL_W = 64;
   localparam int unsigned CMD_W = 10;

   // ROB word: ready/valid flag above a 64-bit operand value.
   typedef struct packed {
      logic             rdy;
      logic [VAL_W-1:0] val;
   } rob_word_t;

   // Take the broadcast value when the operand is still pending and its tag matches.
   function automatic rob_word_t wake(rob_word_t cur, logic tag_hit, rob_word_t bcast);
      rob_word_t res;
      res = cur;
      if (!cur.rdy && tag_hit && bcast.rdy) begin
         res.rdy = 1'b1;
         res.val = bcast.val;
      end
      return res;
   endfunction

endpackage

// File: rtl/bsg_priority_encode_one_hot_out.sv
// One-hot priority select; lo_to_hi_p=1 gives bit 0 the highest priority.
module bsg_priority_encode_one_hot_out #(
   parameter int unsigned width_p    = 2,
   parameter bit          lo_to_hi_p = 1'b1
) (
   input  logic [width_p-1:0] i,
   output logic [width_p-1:0] o,
   output logic               v_o
);

   logic found;

   always_comb begin
      o     = '0;
      found = 1'b0;
      if (lo_to_hi_p) begin
         for (int k = 0; k < int'(width_p); k++) begin
            if (i[k] && !found) begin
               o[k]  = 1'b1;
               found = 1'b1;
            end
         end
      end else begin
         for (int k = int'(width_p) - 1; k >= 0; k--) begin
            if (i[k] && !found) begin
               o[k]  = 1'b1;
               found = 1'b1;
            end
         end
      end
   end

   assign v_o = |i;

endmodule

// File: rtl/reservation_station.sv
// One reservation-station entry: decode write, broadcast wakeup, issue release.
module reservation_station
   import dual_reservation_station_pkg::*;
#(
   parameter int unsigned TAG_W = 6
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             write_i,
   input  rob_word_t        op1_i,
   input  rob_word_t        op2_i,
   input  logic [TAG_W-1:0] tag1_i,
   input  logic [TAG_W-1:0] tag2_i,
   input  logic [TAG_W-1:0] dest_i,
   input  logic [CMD_W-1:0] cmd_i,
   input  logic [TAG_W-1:0] bcast_tag_i,
   input  rob_word_t        bcast_i,
   input  logic             stall_i,
   output logic             busy_o,
   output logic             ready_o,
   output logic [VAL_W-1:0] val1_o,
   output logic [VAL_W-1:0] val2_o,
   output logic [TAG_W-1:0] dest_o,
   output logic [CMD_W-1:0] cmd_o
);

   logic             busy_q,  busy_d;
   logic             ready_q, ready_d;
   rob_word_t        op1_q,   op1_d;
   rob_word_t        op2_q,   op2_d;
   logic [TAG_W-1:0] tag1_q,  tag1_d;
   logic [TAG_W-1:0] tag2_q,  tag2_d;
   logic [TAG_W-1:0] dest_q,  dest_d;
   logic [CMD_W-1:0] cmd_q,   cmd_d;

   always_comb begin
      busy_d = busy_q;
      op1_d  = op1_q;
      op2_d  = op2_q;
      tag1_d = tag1_q;
      tag2_d = tag2_q;
      dest_d = dest_q;
      cmd_d  = cmd_q;
      if (busy_q) begin
         op1_d = wake(op1_q, tag1_q == bcast_tag_i, bcast_i);
         op2_d = wake(op2_q, tag2_q == bcast_tag_i, bcast_i);
         // Release only when this entry is the selected one and downstream accepts.
         if (ready_q && !stall_i) begin
            busy_d = 1'b0;
         end
      end else if (write_i) begin
         busy_d = 1'b1;
         op1_d  = wake(op1_i, tag1_i == bcast_tag_i, bcast_i);
         op2_d  = wake(op2_i, tag2_i == bcast_tag_i, bcast_i);
         tag1_d = tag1_i;
         tag2_d = tag2_i;
         dest_d = dest_i;
         cmd_d  = cmd_i;
      end
      // Ready tracks the next registered state, so it never bypasses a same-cycle broadcast.
      ready_d = busy_d & op1_d.rdy & op2_d.rdy;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         op1_q   <= '0;
         op2_q   <= '0;
         tag1_q  <= '0;
         tag2_q  <= '0;
         dest_q  <= '0;
         cmd_q   <= '0;
      end else begin
         busy_q  <= busy_d;
         ready_q <= ready_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         tag1_q  <= tag1_d;
         tag2_q  <= tag2_d;
         dest_q  <= dest_d;
         cmd_q   <= cmd_d;
      end
   end

   assign busy_o  = busy_q;
   assign ready_o = ready_q;
   assign val1_o  = op1_q.val;
   assign val2_o  = op2_q.val;
   assign dest_o  = dest_q;
   assign cmd_o   = cmd_q;

endmodule

// File: rtl/dual_reservation_station.sv
// Two-entry reservation station feeding one execution unit.
module dual_reservation_station
   import dual_reservation_station_pkg::*;
#(
   parameter int unsigned ROBsize    = 32,
   parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [ROBsizeLog-1:0] decodeROBTag1_i,
   input  logic [ROBsizeLog-1:0] decodeROBTag2_i,
   input  logic [ROBsizeLog-1:0] decodeROBTag_i,
   input  logic                  decodeWriteEn_i,
   input  logic [VAL_W:0]        decodeROBval1_i,
   input  logic [VAL_W:0]        decodeROBval2_i,
   input  logic [CMD_W-1:0]      decodeCommands_i,
   output logic                  stall_o,
   input  logic [ROBsizeLog-1:0] issueROBTag_i,
   input  logic [VAL_W:0]        issueROBval_i,
   input  logic                  stall_i,
   output logic [VAL_W-1:0]      reservationStationVal1_o,
   output logic [VAL_W-1:0]      reservationStationVal2_o,
   output logic [CMD_W-1:0]      reservationStationCommands_o,
   output logic [ROBsizeLog-1:0] reservationStationTag_o,
   output logic                  ready_o
);

   logic [1:0]            busy;
   logic [1:0]            rdy;
   logic [1:0]            alloc_oh;
   logic [1:0]            issue_oh;
   logic                  alloc_v;
   logic                  issue_v;
   logic [VAL_W-1:0]      val1 [2];
   logic [VAL_W-1:0]      val2 [2];
   logic [ROBsizeLog-1:0] dest [2];
   logic [CMD_W-1:0]      cmd  [2];

   bsg_priority_encode_one_hot_out #(.width_p(2), .lo_to_hi_p(1'b1)) u_alloc (
      .i   (~busy),
      .o   (alloc_oh),
      .v_o (alloc_v)
   );

   bsg_priority_encode_one_hot_out #(.width_p(2), .lo_to_hi_p(1'b1)) u_issue (
      .i   (rdy),
      .o   (issue_oh),
      .v_o (issue_v)
   );

   for (genvar g = 0; g < 2; g++) begin : g_entry
      reservation_station #(.TAG_W(ROBsizeLog)) u_entry (
         .clk_i       (clk_i),
         .reset_i     (reset_i),
         .write_i     (decodeWriteEn_i & alloc_oh[g]),
         .op1_i       (rob_word_t'(decodeROBval1_i)),
         .op2_i       (rob_word_t'(decodeROBval2_i)),
         .tag1_i      (decodeROBTag1_i),
         .tag2_i      (decodeROBTag2_i),
         .dest_i      (decodeROBTag_i),
         .cmd_i       (decodeCommands_i),
         .bcast_tag_i (issueROBTag_i),
         .bcast_i     (rob_word_t'(issueROBval_i)),
         .stall_i     (~issue_oh[g] | stall_i),
         .busy_o      (busy[g]),
         .ready_o     (rdy[g]),
         .val1_o      (val1[g]),
         .val2_o      (val2[g]),
         .dest_o      (dest[g]),
         .cmd_o       (cmd[g])
      );
   end

   assign stall_o = ~alloc_v;
   assign ready_o = issue_v;

   // Entry 0 is shown by default, including when nothing is ready.
   assign reservationStationVal1_o     = issue_oh[1] ? val1[1] : val1[0];
   assign reservationStationVal2_o     = issue_oh[1] ? val2[1] : val2[0];
   assign reservationStationCommands_o = issue_oh[1] ? cmd[1]  : cmd[0];
   assign reservationStationTag_o      = issue_oh[1] ? dest[1] : dest[0];

endmodule

// File: tb/tb_dual_reservation_station.sv
// Randomized self-checking bench for dual_reservation_station against a behavioural model.
module tb_dual_reservation_station;

   localparam int unsigned TW = 6;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b0;
   logic [TW-1:0] decodeROBTag1_i, decodeROBTag2_i, decodeROBTag_i;
   logic          decodeWriteEn_i;
   logic [64:0]   decodeROBval1_i, decodeROBval2_i;
   logic [9:0]    decodeCommands_i;
   logic          stall_o;
   logic [TW-1:0] issueROBTag_i;
   logic [64:0]   issueROBval_i;
   logic          stall_i;
   logic [63:0]   reservationStationVal1_o, reservationStationVal2_o;
   logic [9:0]    reservationStationCommands_o;
   logic [TW-1:0] reservationStationTag_o;
   logic          ready_o;

   dual_reservation_station #(.ROBsize(32)) dut (
      .clk_i                        (clk_i),
      .reset_i                      (reset_i),
      .decodeROBTag1_i              (decodeROBTag1_i),
      .decodeROBTag2_i              (decodeROBTag2_i),
      .decodeROBTag_i               (decodeROBTag_i),
      .decodeWriteEn_i              (decodeWriteEn_i),
      .decodeROBval1_i              (decodeROBval1_i),
      .decodeROBval2_i              (decodeROBval2_i),
      .decodeCommands_i             (decodeCommands_i),
      .stall_o                      (stall_o),
      .issueROBTag_i                (issueROBTag_i),
      .issueROBval_i                (issueROBval_i),
      .stall_i                      (stall_i),
      .reservationStationVal1_o     (reservationStationVal1_o),
      .reservationStationVal2_o     (reservationStationVal2_o),
      .reservationStationCommands_o (reservationStationCommands_o),
      .reservationStationTag_o      (reservationStationTag_o),
      .ready_o                      (ready_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit            busy;
      bit            r1, r2;
      logic [63:0]   v1, v2;
      logic [TW-1:0] t1, t2, d;
      logic [9:0]    c;
   } ent_t;

   ent_t m[2];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_ready(int i);
      return m[i].busy && m[i].r1 && m[i].r2;
   endfunction

   // Compare current outputs to the model, then advance the model and the DUT one clock.
   task automatic tick();
      ent_t n[2];
      int   iss, al, e;
      iss = -1;
      al  = -1;
      for (int i = 0; i < 2; i++) begin
         if (iss < 0 && m_ready(i)) iss = i;
         if (al < 0 && !m[i].busy) al = i;
      end
      e = (iss == 1) ? 1 : 0;
      check("ready_o", 64'(ready_o), 64'(iss >= 0));
      check("stall_o", 64'(stall_o), 64'(m[0].busy && m[1].busy));
      check("val1",    reservationStationVal1_o, m[e].v1);
      check("val2",    reservationStationVal2_o, m[e].v2);
      check("tag",     64'(reservationStationTag_o), 64'(m[e].d));
      check("cmd",     64'(reservationStationCommands_o), 64'(m[e].c));
      n = m;
      for (int i = 0; i < 2; i++) begin
         if (m[i].busy) begin
            if (!m[i].r1 && issueROBval_i[64] && issueROBTag_i == m[i].t1) begin
               n[i].r1 = 1; n[i].v1 = issueROBval_i[63:0];
            end
            if (!m[i].r2 && issueROBval_i[64] && issueROBTag_i == m[i].t2) begin
               n[i].r2 = 1; n[i].v2 = issueROBval_i[63:0];
            end
            if (i == iss && !stall_i) n[i].busy = 0;
         end else if (i == al && decodeWriteEn_i) begin
            n[i].busy = 1;
            n[i].r1 = decodeROBval1_i[64]; n[i].v1 = decodeROBval1_i[63:0];
            n[i].r2 = decodeROBval2_i[64]; n[i].v2 = decodeROBval2_i[63:0];
            if (!n[i].r1 && issueROBval_i[64] && issueROBTag_i == decodeROBTag1_i) begin
               n[i].r1 = 1; n[i].v1 = issueROBval_i[63:0];
            end
            if (!n[i].r2 && issueROBval_i[64] && issueROBTag_i == decodeROBTag2_i) begin
               n[i].r2 = 1; n[i].v2 = issueROBval_i[63:0];
            end
            n[i].t1 = decodeROBTag1_i; n[i].t2 = decodeROBTag2_i;
            n[i].d  = decodeROBTag_i;  n[i].c  = decodeCommands_i;
         end
      end
      @(posedge clk_i);
      m = n;
      @(negedge clk_i);
      #1;
   endtask

   task automatic set_write(input bit en, input bit r1, input logic [63:0] v1, input logic [TW-1:0] t1,
                            input bit r2, input logic [63:0] v2, input logic [TW-1:0] t2,
                            input logic [TW-1:0] d, input logic [9:0] c);
      decodeWriteEn_i  = en;
      decodeROBval1_i  = {r1, v1};
      decodeROBval2_i  = {r2, v2};
      decodeROBTag1_i  = t1;
      decodeROBTag2_i  = t2;
      decodeROBTag_i   = d;
      decodeCommands_i = c;
   endtask

   task automatic set_bcast(input bit v, input logic [TW-1:0] t, input logic [63:0] val);
      issueROBval_i = {v, val};
      issueROBTag_i = t;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) m[i] = '{default: '0};
      set_write(0, 0, 64'd0, '0, 0, 64'd0, '0, '0, '0);
      set_bcast(0, '0, 64'd0);
      stall_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b1;
      #1;

      // Reset state.
      check("rst_ready", 64'(ready_o), 64'd0);
      check("rst_stall", 64'(stall_o), 64'd0);
      check("rst_val1",  reservationStationVal1_o, 64'd0);
      check("rst_tag",   64'(reservationStationTag_o), 64'd0);

      // Single ready write issues one cycle later and frees the next edge.
      set_write(1, 1, 64'hA, 6'd0, 1, 64'hB, 6'd0, 6'd3, 10'd10);
      tick();
      set_write(0, 0, 64'd0, '0, 0, 64'd0, '0, '0, '0);
      check("w1_ready", 64'(ready_o), 64'd1);
      check("w1_val1",  reservationStationVal1_o, 64'hA);
      check("w1_val2",  reservationStationVal2_o, 64'hB);
      check("w1_tag",   64'(reservationStationTag_o), 64'd3);
      check("w1_cmd",   64'(reservationStationCommands_o), 64'd10);
      tick();
      check("w1_freed", 64'(ready_o), 64'd0);

      // Both entries wait on tag 10; one broadcast wakes both.
      set_write(1, 0, 64'd0, 6'd10, 0, 64'd0, 6'd10, 6'd11, 10'd1);
      tick();
      tick();
      set_write(0, 0, 64'd0, '0, 0, 64'd0, '0, '0, '0);
      check("w2_stall", 64'(stall_o), 64'd1);
      check("w2_notrdy", 64'(ready_o), 64'd0);
      set_bcast(1, 6'd10, 64'hD);
      tick();
      set_bcast(0, '0, 64'd0);
      check("w2_rdy0", 64'(ready_o), 64'd1);
      check("w2_v0",   reservationStationVal2_o, 64'hD);
      tick();
      check("w2_rdy1", 64'(ready_o), 64'd1);
      check("w2_v1",   reservationStationVal1_o, 64'hD);
      check("w2_stall_clr", 64'(stall_o), 64'd0);
      tick();
      check("w2_empty", 64'(ready_o), 64'd0);

      // Downstream stall holds both ready entries until released.
      stall_i = 1'b1;
      set_write(1, 1, 64'h11, 6'd0, 1, 64'h12, 6'd0, 6'd20, 10'd2);
      tick();
      set_write(1, 1, 64'h21, 6'd0, 1, 64'h22, 6'd0, 6'd21, 10'd3);
      tick();
      set_write(0, 0, 64'd0, '0, 0, 64'd0, '0, '0, '0);
      tick();
      check("st_stall", 64'(stall_o), 64'd1);
      check("st_ready", 64'(ready_o), 64'd1);
      check("st_tag0",  64'(reservationStationTag_o), 64'd20);
      stall_i = 1'b0;
      tick();
      check("st_tag1",  64'(reservationStationTag_o), 64'd21);
      check("st_open",  64'(stall_o), 64'd0);
      tick();

      // Random traffic against the model.
      for (int k = 0; k < 4000; k++) begin
         set_write($urandom_range(0, 1), $urandom_range(0, 2) != 0, {$urandom, $urandom},
                   TW'($urandom_range(1, 7)), $urandom_range(0, 2) != 0, {$urandom, $urandom},
                   TW'($urandom_range(1, 7)), TW'($urandom), 10'($urandom));
         set_bcast($urandom_range(0, 1), TW'($urandom_range(1, 7)), {$urandom, $urandom});
         stall_i = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
